// File: rtl/ghost_dir_picker.sv
// rtl/ghost_dir_picker.sv - picks a legal ghost direction from a random candidate and the wall mask
// Optional macro GHOST_DIR_REVERSE_EN lets the scan accept the reverse of the current direction.
module ghost_dir_picker #(
  parameter logic [1:0] DIR_RESET = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] rand_in,
  input  logic [3:0] walls,
  output logic [1:0] dir,
  output logic       done,
  output logic       busy,
  output logic       stuck
);

  typedef enum logic [1:0] {IDLE, CHECK, FALLBACK, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [1:0] tries_q, tries_d;
  logic [3:0] wall_q, wall_d;
  logic [1:0] dir_q, dir_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       stuck_q, stuck_d;

  logic [1:0] rev_dir;
  logic       cand_legal;

  assign rev_dir = dir_q + 2'd2;

`ifdef GHOST_DIR_REVERSE_EN
  assign cand_legal = !wall_q[cand_q];
`else
  assign cand_legal = !wall_q[cand_q] && (cand_q != rev_dir);
`endif

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    tries_d = tries_q;
    wall_d  = wall_q;
    dir_d   = dir_q;
    stuck_d = stuck_q;
    case (state_q)
      IDLE: begin
        // Inputs are captured only here; later changes cannot disturb a pick.
        if (tick) begin
          cand_d  = rand_in;
          wall_d  = walls;
          tries_d = 2'd0;
          stuck_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cand_legal) begin
          dir_d   = cand_q;
          state_d = DONE;
        end else if (tries_q < 2'd3) begin
          cand_d  = cand_q + 2'd1;
          tries_d = tries_q + 2'd1;
        end else begin
          state_d = FALLBACK;
        end
      end
      FALLBACK: begin
        if (!wall_q[rev_dir]) begin
          dir_d = rev_dir;
        end else begin
          stuck_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= 2'd0;
      tries_q <= 2'd0;
      wall_q  <= 4'd0;
      dir_q   <= DIR_RESET;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      tries_q <= tries_d;
      wall_q  <= wall_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      stuck_q <= stuck_d;
    end
  end

  assign dir   = dir_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign stuck = stuck_q;

endmodule
